// File: rtl/truth_table_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : truth_table_capture
//  Purpose  : Characterises an N_IN-input, single-output combinational block.
//             Walks drv through every input combination. Each value is held for
//             SETTLE cycles, then f_i is sampled, and the results build the
//             minterm mask. The popcount and constant-function flags are
//             produced from the same mask.
//  Ports    : clk        rising-edge clock
//             rst_n      asynchronous active-low reset
//             start      capture request, accepted only while idle
//             f_i        output of the characterised block
//             drv        input vector applied to the block (MSB = a)
//             busy       high while stepping through combinations
//             done       one-cycle pulse when the results update
//             mask       mask[i] = f value observed with drv == i
//             ones_cnt   population count of mask
//             is_const0  mask is all zeros
//             is_const1  mask is all ones
//  Revision : 1.0 - initial release
// ============================================================================
module truth_table_capture #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1      // legal range 1..15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  f_i,
    output logic [N_IN-1:0]       drv,
    output logic                  busy,
    output logic                  done,
    output logic [2**N_IN-1:0]    mask,
    output logic [N_IN:0]         ones_cnt,
    output logic                  is_const0,
    output logic                  is_const1
);

    localparam int              c_MASK_W    = 2**N_IN;
    localparam logic [N_IN-1:0] c_IDX_LAST  = '1;
    localparam logic [3:0]      c_WCNT_INIT = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [N_IN-1:0]       r_idx;
    logic [3:0]            r_wcnt;
    logic [c_MASK_W-1:0]   r_shadow;
    logic [c_MASK_W-1:0]   w_shadow_next;
    logic [N_IN:0]         w_pop;
    logic [c_MASK_W-1:0]   r_mask;
    logic [N_IN:0]         r_ones_cnt;
    logic                  r_is_const0;
    logic                  r_is_const1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore outputs. drv is decoded from state so that it
    // reads 0 outside the stepping states without a separate register.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        drv          = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                drv  = r_idx;
                if (r_wcnt == 4'd0) begin
                    w_state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                busy = 1'b1;
                drv  = r_idx;
                // Terminal compare comes before any increment, so idx never wraps.
                if (r_idx == c_IDX_LAST) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow mask including the bit being sampled this cycle. The published
    // results are taken from this value, so the final minterm is not lost.
    // ------------------------------------------------------------------
    always_comb begin
        w_shadow_next        = r_shadow;
        w_shadow_next[r_idx] = f_i;
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < c_MASK_W; i++) begin
            w_pop = w_pop + {{N_IN{1'b0}}, w_shadow_next[i]};
        end
    end

    // ------------------------------------------------------------------
    // Datapath: index, settle counter, shadow and published results
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_wcnt      <= '0;
            r_shadow    <= '0;
            r_mask      <= '0;
            r_ones_cnt  <= '0;
            r_is_const0 <= 1'b0;
            r_is_const1 <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx    <= '0;
                        r_shadow <= '0;
                        r_wcnt   <= c_WCNT_INIT;
                    end
                end
                S_WAIT: begin
                    if (r_wcnt != 4'd0) begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    r_shadow <= w_shadow_next;
                    if (r_idx == c_IDX_LAST) begin
                        r_mask      <= w_shadow_next;
                        r_ones_cnt  <= w_pop;
                        r_is_const0 <= ~|w_shadow_next;
                        r_is_const1 <= &w_shadow_next;
                    end else begin
                        r_idx  <= r_idx + 1'b1;
                        r_wcnt <= c_WCNT_INIT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mask      = r_mask;
    assign ones_cnt  = r_ones_cnt;
    assign is_const0 = r_is_const0;
    assign is_const1 = r_is_const1;

endmodule
`default_nettype wire
